// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing one register-file write port
// among NREQ requesters with val/rdy handshakes.
//
// Build option: define REGFILE_WR_ARB_CLEAR_EN to compile in the post-reset
// clear sequencer, which writes zero to every register before arbitration
// starts. Without it the arbiter enters normal arbitration straight out of
// reset and relies on the register file's own reset for initial contents.

module regfile_wr_arbiter #(
    parameter  int NREQ  = 3,
    parameter  int DTYPE = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DTYPE-1:0] req_data,
    output logic                  wr_call,
    output logic [AW-1:0]         wr_addr,
    output logic [DTYPE-1:0]      wr_data,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    localparam int unsigned NREQ_U = NREQ;

    // Per-requester views of the packed address/data buses.
    logic [AW-1:0]    addr_arr [NREQ];
    logic [DTYPE-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*AW +: AW];
        assign data_arr[g] = req_data[g*DTYPE +: DTYPE];
    end

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] winner;
    logic          found;
    logic          clearing;
    logic [AW-1:0] clr_addr;

`ifdef REGFILE_WR_ARB_CLEAR_EN
    typedef enum logic {
        CLEAR,
        RUN
    } fsm_t;

    fsm_t          fsm;
    fsm_t          fsm_nxt;
    logic [AW-1:0] clr_ctr;
    logic [AW-1:0] clr_ctr_nxt;

    // State register for the clear sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= CLEAR;
            clr_ctr <= '0;
        end else begin
            fsm     <= fsm_nxt;
            clr_ctr <= clr_ctr_nxt;
        end
    end

    // Next-state logic: walk every address once, then hand over to arbitration.
    always_comb begin
        fsm_nxt     = fsm;
        clr_ctr_nxt = clr_ctr;
        case (fsm)
            CLEAR: begin
                if (clr_ctr == AW'(NREGS - 1)) begin
                    fsm_nxt     = RUN;
                    clr_ctr_nxt = '0;
                end else begin
                    clr_ctr_nxt = clr_ctr + 1'b1;
                end
            end
            default: begin
                fsm_nxt     = RUN;
                clr_ctr_nxt = '0;
            end
        endcase
    end

    assign clearing = (fsm == CLEAR);
    assign clr_addr = clr_ctr;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // Round-robin search: first valid requester at or after rr_ptr, modulo NREQ.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            if (!found && req_val[GW'(idx)]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // Pointer moves just past the winner after each grant; idle cycles hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!clearing && found) begin
            if (winner == GW'(NREQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner + 1'b1;
            end
        end
    end

    // Write-port and handshake outputs; reset and clearing take priority over grants.
    always_comb begin
        req_rdy  = '0;
        wr_call  = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        grant_id = '0;
        busy     = 1'b0;
        if (reset) begin
            busy = 1'b1;
        end else if (clearing) begin
            wr_call = 1'b1;
            wr_addr = clr_addr;
            busy    = 1'b1;
        end else if (found) begin
            req_rdy  = NREQ'(1) << winner;
            wr_call  = 1'b1;
            wr_addr  = addr_arr[winner];
            wr_data  = data_arr[winner];
            grant_id = winner;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench for regfile_wr_arbiter.
// A reference model predicts each cycle's write-port response from the
// pending requests; a monitor compares the DUT against the queued predictions.
// A behavioural register file, written by the DUT, is checked against the
// model's expected contents. Honours REGFILE_WR_ARB_CLEAR_EN like the design.

module tb_regfile_wr_arbiter;

    localparam int NREQ  = 3;
    localparam int DTYPE = 8;
    localparam int NREGS = 4;
    localparam int AW    = 2;
    localparam int GW    = 2;

`ifdef REGFILE_WR_ARB_CLEAR_EN
    localparam bit CLEAR_BUILD = 1'b1;
`else
    localparam bit CLEAR_BUILD = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_val = '0;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*AW-1:0]    req_addr = '0;
    logic [NREQ*DTYPE-1:0] req_data = '0;
    logic                  wr_call;
    logic [AW-1:0]         wr_addr;
    logic [DTYPE-1:0]      wr_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    regfile_wr_arbiter #(.NREQ(NREQ), .DTYPE(DTYPE), .NREGS(NREGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_addr (req_addr),
        .req_data (req_data),
        .wr_call  (wr_call),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file fed by the DUT write port.
    logic [DTYPE-1:0] rf [NREGS];
    always @(posedge clk) begin
        if (reset && !CLEAR_BUILD) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_call) begin
            rf[wr_addr] <= wr_data;
        end
    end

    typedef struct {
        logic             call;
        logic [AW-1:0]    addr;
        logic [DTYPE-1:0] data;
        logic [GW-1:0]    gid;
        logic [NREQ-1:0]  rdy;
        logic             busy;
        bit               chk_ad;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Requester state and reference model state.
    bit   [NREQ-1:0]  pend = '0;
    logic [AW-1:0]    paddr [NREQ];
    logic [DTYPE-1:0] pdata [NREQ];
    logic [AW-1:0]    dir_addr [NREQ];
    logic [DTYPE-1:0] dir_data [NREQ];
    logic [NREQ-1:0]  rdy_seen = '0;
    int               mptr = 0;
    int               clr_left = 0;
    int               mclr = 0;
    logic [DTYPE-1:0] mem_exp [NREGS];
    bit               known [NREGS];
    bit               mem_chk_en = 1'b0;

    // Monitor: every observed cycle pops one prediction and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: DUT cycle with no prediction, wr_call=%0b", wr_call);
                end else begin
                    e = sbq.pop_front();
                    if (wr_call !== e.call || req_rdy !== e.rdy || grant_id !== e.gid ||
                        busy !== e.busy ||
                        (e.chk_ad && (wr_addr !== e.addr || wr_data !== e.data))) begin
                        n_fail++;
                        $display("FAIL wr_port t=%0t: got call=%0b rdy=%b gid=%0d busy=%0b addr=%0d data=%h, need call=%0b rdy=%b gid=%0d busy=%0b addr=%0d data=%h",
                                 $time, wr_call, req_rdy, grant_id, busy, wr_addr, wr_data,
                                 e.call, e.rdy, e.gid, e.busy, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check_mem();
        for (int i = 0; i < NREGS; i++) begin
            if (known[i]) begin
                n_tests++;
                if (rf[i] !== mem_exp[i]) begin
                    n_fail++;
                    $display("FAIL rf_read addr=%0d: got %h, need %h", i, rf[i], mem_exp[i]);
                end
            end
        end
    endtask

    // One clock cycle: retire transferred requests, add new ones, predict, drive.
    task automatic step(input bit rst, input logic [NREQ-1:0] add_mask, input bit rand_en);
        exp_t e;
        int   w;
        int   j;
        @(posedge clk);
        #1;
        if (mem_chk_en) check_mem();
        pend = pend & ~rdy_seen;
        reset = rst;
        e = '{call: 1'b0, addr: '0, data: '0, gid: '0, rdy: '0, busy: 1'b0, chk_ad: 1'b1};
        if (rst) begin
            pend     = '0;
            mptr     = 0;
            mclr     = 0;
            clr_left = CLEAR_BUILD ? NREGS : 0;
            if (!CLEAR_BUILD) begin
                for (int i = 0; i < NREGS; i++) begin
                    mem_exp[i] = '0;
                    known[i]   = 1'b1;
                end
            end
            e.busy   = 1'b1;
            e.chk_ad = 1'b0;
            mem_chk_en = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (add_mask[i] && !pend[i]) begin
                    pend[i]  = 1'b1;
                    paddr[i] = rand_en ? AW'($urandom_range(0, NREGS - 1)) : dir_addr[i];
                    pdata[i] = rand_en ? DTYPE'($urandom) : dir_data[i];
                end
            end
            if (clr_left > 0) begin
                e.call = 1'b1;
                e.addr = AW'(mclr);
                e.busy = 1'b1;
                mem_exp[mclr] = '0;
                known[mclr]   = 1'b1;
                mclr++;
                clr_left--;
            end else begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (w < 0 && pend[j]) w = j;
                end
                if (w >= 0) begin
                    e.call = 1'b1;
                    e.addr = paddr[w];
                    e.data = pdata[w];
                    e.gid  = GW'(w);
                    e.rdy  = NREQ'(1 << w);
                    mem_exp[paddr[w]] = pdata[w];
                    known[paddr[w]]   = 1'b1;
                    mptr = (w + 1) % NREQ;
                end
            end
        end
        req_val = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = paddr[i];
            req_data[i*DTYPE +: DTYPE] = pdata[i];
        end
        sbq.push_back(e);
        @(negedge clk);
        rdy_seen = req_rdy;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            paddr[i] = '0;
            pdata[i] = '0;
            dir_addr[i] = '0;
            dir_data[i] = '0;
        end
        for (int i = 0; i < NREGS; i++) begin
            mem_exp[i] = '0;
            known[i]   = 1'b0;
        end
        mon_en = 1'b1;

        // Reset for two cycles, then the clear sequence (if built) and settle.
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        repeat (NREGS + 2) step(1'b0, '0, 1'b0);

        // All requesters valid for six cycles starting from pointer 0.
        repeat (6) step(1'b0, 3'b111, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0);

        // Single request from requester 1.
        dir_addr[1] = 2'd2;
        dir_data[1] = 8'hA5;
        step(1'b0, 3'b010, 1'b0);
        step(1'b0, '0, 1'b0);

        // Requester 0 alone moves the pointer to 1, then skip-and-wrap with 3'b101.
        dir_addr[0] = 2'd1;
        dir_data[0] = 8'h3C;
        dir_addr[2] = 2'd3;
        dir_data[2] = 8'h5A;
        step(1'b0, 3'b001, 1'b0);
        step(1'b0, 3'b101, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);

        // Randomized traffic with a reset in the middle.
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                step(1'b1, '0, 1'b0);
            end else begin
                step(1'b0, NREQ'($urandom), 1'b1);
            end
        end

        // Reset again, then reset while the clear counter is at 2.
        step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        repeat (NREGS + 2) step(1'b0, 3'b011, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0);

        // Request present on the very first cycle after reset.
        step(1'b1, '0, 1'b0);
        dir_addr[0] = 2'd0;
        dir_data[0] = 8'h77;
        step(1'b0, 3'b001, 1'b0);
        repeat (NREGS + 3) step(1'b0, '0, 1'b0);

        @(posedge clk);
        #1;
        check_mem();
        mon_en = 1'b0;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d predictions left, need 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
